ipid_collect: RTL and testbench
===============================

# ipid_collect

Receive-side counterpart of the IPID chunk serializer. The block consumes the framed 16-bit chunk stream: start word 16'h7A7A, sixteen payload chunks with the least-significant chunk first, and stop word 16'hB9B9. It reassembles the 256-bit IPID and reports either a completed frame or a framing error. It sits directly downstream of the serializer on the security-controller side of the IPID link.

## Interface
- No parameters. Framing words are package constants.
- Reset rst, asynchronous, active-low; clock clk.
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous, active-low reset.
- valid_in  in  1  chunk_in is valid this cycle.
- chunk_in  in  16  stream word.
- clear  in  1  acknowledge; returns the block to IDLE and drops ipid_valid/frame_err.
- ipid_out  out  256  last successfully received IPID.
- ipid_valid  out  1  a good frame has been captured; held until clear.
- frame_err  out  1  framing violation; held until clear.
- busy  out  1  high in PAYLOAD and STOP.
- ipid_golden  in  256  expected IPID. Present only with IPID_MATCH_EN.
- match  out  1  ipid_out == ipid_golden at capture. Present only with IPID_MATCH_EN.

## Operation
- States: IDLE, PAYLOAD, STOP, DONE, ERROR. There are 5 states, held in a 3-bit register.
- IDLE:
  - valid_in && chunk_in==7A7A -> PAYLOAD, with cnt=0.
  - Any other word, valid or not, is ignored.
- PAYLOAD:
  - Each cycle with valid_in: shadow[16*cnt +: 16] <= chunk_in, then cnt++.
  - When cnt==15 is captured -> STOP.
  - valid_in low in PAYLOAD -> ERROR. The stream is contiguous and no gaps are allowed.
  - A start word arriving as payload is stored as data; there is no resync.
- STOP:
  - valid_in && chunk_in==B9B9 -> DONE, and ipid_out <= shadow.
  - Anything else, including valid_in low -> ERROR.
- DONE: ipid_valid=1. Input is ignored until clear.
- ERROR: frame_err=1. ipid_out is unchanged. Input is ignored until clear.
- clear:
  - Wins over every other event in any state. Next state is IDLE; cnt and shadow are zeroed.
  - ipid_out is retained.
  - clear in IDLE is a no-op; a start word in the same cycle is dropped.
- cnt is 4 bits and never wraps. The transition out of PAYLOAD occurs at 15.
- ipid_out updates only on a good stop word. A partial or failed frame never corrupts it.

## Timing
- Reset values:
  - State IDLE, cnt 0, shadow 0.
  - ipid_out 0, ipid_valid 0, frame_err 0, busy 0, match 0.
- Latency: with the start word at cycle T, payload occupies T+1..T+16 and the stop word T+17.
  - ipid_valid and ipid_out are visible from T+18.
  - match is valid in the same cycle as ipid_valid.
- frame_err is asserted the cycle after the offending input cycle.
- busy is high from T+1 through T+17 inclusive.
- All outputs are registered. There is no combinational path from input to output.
- Reset asserted mid-frame returns immediately to reset values. The partial frame is lost.

## Configuration
- IPID_MATCH_EN defined:
  - Adds the ipid_golden port and the match output.
  - On the DONE transition, match <= (shadow == ipid_golden).
  - match is cleared by clear and by reset.
- IPID_MATCH_EN undefined: neither port exists and there is no comparator logic.

## Structure
- Shared package ipid_pkg holds:
  - IPID_START_WORD = 16'h7A7A and IPID_STOP_WORD = 16'hB9B9.
  - IPID_CHUNKS = 16.
  - The typedef for the collector state enum.
- The serializer migrates to the same constants.
- Single module with no sub-modules. The comparator is inline under the macro.

## Test plan
- Reset, then send 7A7A followed by chunks 0x0000..0x000F contiguous, then B9B9 -> from T+18, ipid_valid=1 and ipid_out=256'h000F_000E_…_0001_0000; frame_err=0.
- Same frame with valid_in dropped for one cycle after the 5th payload chunk -> frame_err=1 one cycle later; ipid_out unchanged at 0; busy=0.
- Good frame, but the word after the 16th chunk is 0xB9B8 -> frame_err=1; ipid_out keeps its previous value.
- In IDLE, send 0x1234 and 0xB9B9 with valid, then a good frame -> the noise is ignored and the good frame is captured normally.
- Assert clear in DONE -> next cycle IDLE, ipid_valid=0, ipid_out retained. Then assert rst low mid-PAYLOAD -> all outputs are 0 immediately.
- With IPID_MATCH_EN: ipid_golden equal to the sent ID -> match=1; flip bit 200 of the golden value -> match=0 while ipid_valid=1.

Source files
------------

// File: rtl/ipid_pkg.sv
// Shared IPID link constants, collector state encoding and chunk-insert helper.
// Used by both the chunk serializer and the receive-side collector.
package ipid_pkg;

  localparam int IPID_W       = 256;
  localparam int IPID_CHUNK_W = 16;
  localparam int IPID_CHUNKS  = 16;

  localparam logic [IPID_CHUNK_W-1:0] IPID_START_WORD = 16'h7A7A;
  localparam logic [IPID_CHUNK_W-1:0] IPID_STOP_WORD  = 16'hB9B9;

  // Index of the final payload chunk; the counter saturates here.
  localparam logic [3:0] IPID_LAST_CNT = 4'(IPID_CHUNKS - 1);

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_PAYLOAD = 3'd1,
    ST_STOP    = 3'd2,
    ST_DONE    = 3'd3,
    ST_ERROR   = 3'd4
  } ipid_col_state_t;

  function automatic logic [IPID_W-1:0] ipid_put_chunk(
    input logic [IPID_W-1:0]       shadow,
    input logic [3:0]              idx,
    input logic [IPID_CHUNK_W-1:0] chunk
  );
    logic [IPID_W-1:0] r;
    r = shadow;
    r[IPID_CHUNK_W*idx +: IPID_CHUNK_W] = chunk;
    return r;
  endfunction

endpackage

// File: rtl/ipid_collect.sv
// Reassembles the framed 16-bit IPID chunk stream into 256 bits; result visible 18 cycles after the start word.
// No backpressure: the stream must be gap-free, gaps/bad stop raise frame_err until clear. IPID_MATCH_EN adds golden compare.
module ipid_collect
  import ipid_pkg::*;
(
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    valid_in,
  input  logic [IPID_CHUNK_W-1:0] chunk_in,
  input  logic                    clear,
`ifdef IPID_MATCH_EN
  input  logic [IPID_W-1:0]       ipid_golden,
  output logic                    match,
`endif
  output logic [IPID_W-1:0]       ipid_out,
  output logic                    ipid_valid,
  output logic                    frame_err,
  output logic                    busy
);

  ipid_col_state_t state_q, state_d;

  logic [3:0]        cnt_q, cnt_d;
  logic [IPID_W-1:0] shadow_q, shadow_d;
  logic [IPID_W-1:0] ipid_out_q, ipid_out_d;
  logic              ipid_valid_q, ipid_valid_d;
  logic              frame_err_q, frame_err_d;
  logic              busy_q, busy_d;

  logic start_hit;
  logic stop_hit;

  assign start_hit = valid_in && (chunk_in == IPID_START_WORD);
  assign stop_hit  = valid_in && (chunk_in == IPID_STOP_WORD);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // clear overrides every input event, including a start word seen in IDLE.
  always_comb begin
    state_d = state_q;
    if (clear) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (start_hit) state_d = ST_PAYLOAD;
        end
        ST_PAYLOAD: begin
          if (!valid_in)                  state_d = ST_ERROR;
          else if (cnt_q == IPID_LAST_CNT) state_d = ST_STOP;
        end
        ST_STOP: begin
          state_d = stop_hit ? ST_DONE : ST_ERROR;
        end
        ST_DONE:  state_d = ST_DONE;
        ST_ERROR: state_d = ST_ERROR;
        default:  state_d = ST_IDLE;
      endcase
    end
  end

  always_comb begin
    ipid_valid_d = (state_d == ST_DONE);
    frame_err_d  = (state_d == ST_ERROR);
    busy_d       = (state_d == ST_PAYLOAD) || (state_d == ST_STOP);
  end

  // Payload lands in a shadow so ipid_out only ever changes on a good stop word.
  always_comb begin
    cnt_d      = cnt_q;
    shadow_d   = shadow_q;
    ipid_out_d = ipid_out_q;
    if (clear) begin
      cnt_d    = '0;
      shadow_d = '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (start_hit) cnt_d = '0;
        end
        ST_PAYLOAD: begin
          if (valid_in) begin
            shadow_d = ipid_put_chunk(shadow_q, cnt_q, chunk_in);
            if (cnt_q != IPID_LAST_CNT) cnt_d = cnt_q + 4'd1;
          end
        end
        ST_STOP: begin
          if (stop_hit) ipid_out_d = shadow_q;
        end
        default: begin
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q        <= '0;
      shadow_q     <= '0;
      ipid_out_q   <= '0;
      ipid_valid_q <= 1'b0;
      frame_err_q  <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      cnt_q        <= cnt_d;
      shadow_q     <= shadow_d;
      ipid_out_q   <= ipid_out_d;
      ipid_valid_q <= ipid_valid_d;
      frame_err_q  <= frame_err_d;
      busy_q       <= busy_d;
    end
  end

  assign ipid_out   = ipid_out_q;
  assign ipid_valid = ipid_valid_q;
  assign frame_err  = frame_err_q;
  assign busy       = busy_q;

`ifdef IPID_MATCH_EN
  logic match_q, match_d;

  // Compared against the shadow on the capture cycle so match lines up with ipid_valid.
  always_comb begin
    match_d = match_q;
    if (clear) begin
      match_d = 1'b0;
    end else if ((state_q == ST_STOP) && stop_hit) begin
      match_d = (shadow_q == ipid_golden);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      match_q <= 1'b0;
    end else begin
      match_q <= match_d;
    end
  end

  assign match = match_q;
`endif

endmodule

// File: tb/tb_ipid_collect.sv
// Directed bench for ipid_collect with a queue-based frame model checked every cycle.
module tb_ipid_collect;

  localparam logic [15:0] W_START = 16'h7A7A;
  localparam logic [15:0] W_STOP  = 16'hB9B9;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         valid_in = 1'b0;
  logic [15:0]  chunk_in = 16'h0;
  logic         clear = 1'b0;
  logic [255:0] golden = '0;
  logic [255:0] ipid_out;
  logic         ipid_valid;
  logic         frame_err;
  logic         busy;
`ifdef IPID_MATCH_EN
  logic         match;
`endif

  ipid_collect dut (
    .clk        (clk),
    .rst        (rst),
    .valid_in   (valid_in),
    .chunk_in   (chunk_in),
    .clear      (clear),
`ifdef IPID_MATCH_EN
    .ipid_golden(golden),
    .match      (match),
`endif
    .ipid_out   (ipid_out),
    .ipid_valid (ipid_valid),
    .frame_err  (frame_err),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Model: a frame is a start word, exactly 16 contiguous words, then the stop word.
  bit           m_in_frame = 0;
  bit           m_done = 0;
  bit           m_err = 0;
  bit           m_match = 0;
  logic [15:0]  m_q[$];
  logic [255:0] m_ipid = '0;
  bit           chk_en = 0;

  logic [255:0] id0, id1, id2;

  task automatic check_vec(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic check_bit(input string name, input logic act, input logic exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b want %b", name, act, exp);
    end
  endtask

  function automatic logic [255:0] pack_q();
    logic [255:0] r;
    r = '0;
    for (int i = 0; i < m_q.size(); i++) r[16*i +: 16] = m_q[i];
    return r;
  endfunction

  task automatic model_reset();
    m_in_frame = 0;
    m_done     = 0;
    m_err      = 0;
    m_match    = 0;
    m_ipid     = '0;
    m_q.delete();
  endtask

  task automatic model_step(input logic v, input logic [15:0] w, input logic clr);
    if (clr) begin
      m_in_frame = 0; m_done = 0; m_err = 0; m_match = 0;
      m_q.delete();
    end else if (m_done || m_err) begin
    end else if (!m_in_frame) begin
      if (v && w == W_START) begin
        m_in_frame = 1;
        m_q.delete();
      end
    end else if (m_q.size() < 16) begin
      if (v) m_q.push_back(w);
      else begin m_err = 1; m_in_frame = 0; end
    end else begin
      m_in_frame = 0;
      if (v && w == W_STOP) begin
        m_done  = 1;
        m_ipid  = pack_q();
        m_match = (m_ipid == golden);
      end else begin
        m_err = 1;
      end
    end
  endtask

  task automatic step(input logic v, input logic [15:0] w, input logic clr);
    valid_in = v;
    chunk_in = w;
    clear    = clr;
    @(posedge clk);
    model_step(v, w, clr);
    #1;
  endtask

  task automatic send_payload(input logic [255:0] id);
    for (int i = 0; i < 16; i++) step(1'b1, id[16*i +: 16], 1'b0);
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      check_vec("cyc_ipid_out", ipid_out, m_ipid);
      check_bit("cyc_ipid_valid", ipid_valid, m_done);
      check_bit("cyc_frame_err", frame_err, m_err);
      check_bit("cyc_busy", busy, m_in_frame);
`ifdef IPID_MATCH_EN
      check_bit("cyc_match", match, m_match);
`endif
    end
  end

  initial begin
    for (int i = 0; i < 16; i++) begin
      id0[16*i +: 16] = 16'(i);
      id1[16*i +: 16] = 16'hA000 + 16'(i * 16'h0101);
      id2[16*i +: 16] = 16'h7A7A ^ 16'(i * 16'h1111);
    end

    // Reset state
    #12;
    check_vec("rst_ipid_out", ipid_out, 256'h0);
    check_bit("rst_ipid_valid", ipid_valid, 1'b0);
    check_bit("rst_frame_err", frame_err, 1'b0);
    check_bit("rst_busy", busy, 1'b0);
    @(negedge clk);
    rst = 1'b1;
    chk_en = 1;
    step(1'b0, 16'h0, 1'b0);

    // Gap after the 5th payload chunk
    step(1'b1, W_START, 1'b0);
    for (int i = 0; i < 5; i++) step(1'b1, id0[16*i +: 16], 1'b0);
    check_bit("gap_busy_before", busy, 1'b1);
    step(1'b0, 16'h0, 1'b0);
    check_bit("gap_frame_err", frame_err, 1'b1);
    check_bit("gap_busy", busy, 1'b0);
    check_vec("gap_ipid_out", ipid_out, 256'h0);
    step(1'b1, 16'h0005, 1'b0);
    step(1'b1, W_START, 1'b0);
    check_bit("gap_err_held", frame_err, 1'b1);
    step(1'b0, 16'h0, 1'b1);
    check_bit("gap_cleared", frame_err, 1'b0);

    // Good frame 0x0000..0x000F
    golden = id0;
    step(1'b1, W_START, 1'b0);
    check_bit("f0_busy_t1", busy, 1'b1);
    send_payload(id0);
    check_bit("f0_busy_t17", busy, 1'b1);
    check_bit("f0_valid_t17", ipid_valid, 1'b0);
    step(1'b1, W_STOP, 1'b0);
    check_bit("f0_valid_t18", ipid_valid, 1'b1);
    check_bit("f0_busy_t18", busy, 1'b0);
    check_bit("f0_err", frame_err, 1'b0);
    check_vec("f0_ipid_out", ipid_out,
      256'h000F000E000D000C000B000A0009000800070006000500040003000200010000);
`ifdef IPID_MATCH_EN
    check_bit("f0_match", match, 1'b1);
`endif
    step(1'b1, W_START, 1'b0);
    step(1'b0, 16'h0, 1'b0);
    check_bit("f0_done_held", ipid_valid, 1'b1);
    step(1'b0, 16'h0, 1'b1);

    // clear in IDLE drops a simultaneous start word
    step(1'b1, W_START, 1'b1);
    for (int i = 0; i < 3; i++) step(1'b1, 16'h1111, 1'b0);
    check_bit("clr_idle_busy", busy, 1'b0);

    // Bad stop word B9B8
    step(1'b1, W_START, 1'b0);
    send_payload(id1);
    step(1'b1, 16'hB9B8, 1'b0);
    check_bit("badstop_err", frame_err, 1'b1);
    check_bit("badstop_valid", ipid_valid, 1'b0);
    check_vec("badstop_ipid_kept", ipid_out, id0);
    step(1'b0, 16'h0, 1'b1);

    // Gap where the stop word belongs
    step(1'b1, W_START, 1'b0);
    send_payload(id1);
    step(1'b0, W_STOP, 1'b0);
    check_bit("stopgap_err", frame_err, 1'b1);
    step(1'b0, 16'h0, 1'b1);

    // Noise in IDLE then a good frame whose payload contains a start word
    golden = id2;
    step(1'b1, 16'h1234, 1'b0);
    step(1'b1, W_STOP, 1'b0);
    check_bit("noise_busy", busy, 1'b0);
    check_bit("noise_err", frame_err, 1'b0);
    step(1'b1, W_START, 1'b0);
    send_payload(id2);
    step(1'b1, W_STOP, 1'b0);
    check_bit("f2_valid", ipid_valid, 1'b1);
    check_vec("f2_ipid_out", ipid_out, id2);
`ifdef IPID_MATCH_EN
    check_bit("f2_match", match, 1'b1);
`endif

    // clear in DONE
    step(1'b0, 16'h0, 1'b1);
    check_bit("clr_done_valid", ipid_valid, 1'b0);
    check_vec("clr_done_ipid_kept", ipid_out, id2);

`ifdef IPID_MATCH_EN
    golden = id2 ^ (256'h1 << 200);
    step(1'b1, W_START, 1'b0);
    send_payload(id2);
    step(1'b1, W_STOP, 1'b0);
    check_bit("mm_valid", ipid_valid, 1'b1);
    check_bit("mm_match", match, 1'b0);
    step(1'b0, 16'h0, 1'b1);
    check_bit("mm_match_cleared", match, 1'b0);
`endif

    // Reset mid-payload
    step(1'b1, W_START, 1'b0);
    for (int i = 0; i < 6; i++) step(1'b1, id1[16*i +: 16], 1'b0);
    rst = 1'b0;
    model_reset();
    #1;
    check_vec("midrst_ipid_out", ipid_out, 256'h0);
    check_bit("midrst_valid", ipid_valid, 1'b0);
    check_bit("midrst_busy", busy, 1'b0);
    check_bit("midrst_err", frame_err, 1'b0);
    valid_in = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    step(1'b0, 16'h0, 1'b0);

    // Recovery frame after reset
    golden = id1;
    step(1'b1, W_START, 1'b0);
    send_payload(id1);
    step(1'b1, W_STOP, 1'b0);
    check_vec("rec_ipid_out", ipid_out, id1);
    check_bit("rec_valid", ipid_valid, 1'b1);
    step(1'b0, 16'h0, 1'b0);
    step(1'b0, 16'h0, 1'b0);

    chk_en = 0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
